// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for pattern_sequencer: FSM state, committed config layout,
// default channel mask and the auto-cycle mask sequence.
package patseq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  typedef struct packed {
    logic       pal;
    logic       range;
    logic       smpte;
    logic [2:0] mask;
  } cfg_t;

  localparam logic [2:0] MASK_ALL = 3'b111;

  localparam cfg_t CFG_RESET = '{pal: 1'b0, range: 1'b0, smpte: 1'b0, mask: MASK_ALL};

  // Index 0 is the start of the sequence: 111 -> 100 -> 010 -> 001 -> back to 111.
  localparam logic [3:0][2:0] AUTO_SEQ = {3'b001, 3'b010, 3'b100, MASK_ALL};

  function automatic logic cfg_differs(cfg_t a, cfg_t b, logic ign_mask);
    return (a.pal != b.pal) || (a.range != b.range) || (a.smpte != b.smpte) ||
           (!ign_mask && (a.mask != b.mask));
  endfunction

endpackage

// File: rtl/pattern_sequencer_vblank_edge.sv
// ce_pix-gated VBlank rising-edge detector; frame_tick is a one-clk pulse the cycle
// after the qualifying sample. The delayed copy resets high so a VBlank already high at release is ignored.
module vblank_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic ce_pix,
  input  logic vblank,
  output logic frame_tick
);

  logic r_vb_d;
  logic r_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vb_d <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_tick <= ce_pix & vblank & ~r_vb_d;
      if (ce_pix) r_vb_d <= vblank;
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/pattern_sequencer.sv
// Commits requested video config at VBlank boundaries, blanking after PAL/NTSC changes.
// Optional channel-mask auto-cycle is built only when PATSEQ_AUTOCYCLE_EN is defined.
module pattern_sequencer
  import patseq_pkg::*;
#(
  parameter int SETTLE_FRAMES = 4,
  parameter int HOLD_FRAMES   = 60,
  parameter int FCNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              vblank,
  input  logic              req_pal,
  input  logic              req_range,
  input  logic              req_smpte,
  input  logic [2:0]        req_mask,
  input  logic              auto_en,
  output logic              pal,
  output logic              range,
  output logic              smpte,
  output logic [2:0]        chan_mask,
  output logic              force_blank,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int SCNT_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam bit SETTLE_EN = (SETTLE_FRAMES > 0);
  localparam logic [SCNT_W-1:0] SETTLE_INIT = SETTLE_EN ? SCNT_W'(SETTLE_FRAMES - 1) : '0;

  logic              w_frame_tick;
  logic              w_ign_mask;
  logic              w_mismatch;
  logic              w_auto_load;
  logic [2:0]        w_auto_mask;
  cfg_t              w_req;
  cfg_t              w_commit;
  cfg_t              r_act;
  state_e            r_state;
  logic [SCNT_W-1:0] r_settle_cnt;
  logic [FCNT_W-1:0] r_frame_cnt;

  vblank_edge u_vblank_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .vblank     (vblank),
    .frame_tick (w_frame_tick)
  );

  assign w_req = '{pal: req_pal, range: req_range, smpte: req_smpte, mask: req_mask};

`ifdef PATSEQ_AUTOCYCLE_EN
  localparam int HCNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic              r_auto_d;
  logic [HCNT_W-1:0] r_hold_cnt;
  logic [1:0]        r_step_idx;
  logic              w_auto_rise;
  logic              w_auto_adv;
  logic              w_auto_step;

  assign w_ign_mask  = auto_en;
  assign w_auto_rise = auto_en & ~r_auto_d;
  assign w_auto_adv  = (r_state == RUN) && auto_en && !w_auto_rise && w_frame_tick;
  assign w_auto_step = w_auto_adv && (r_hold_cnt == HCNT_W'(HOLD_FRAMES - 1));
  assign w_auto_load = (r_state == RUN) && (w_auto_rise || w_auto_step);
  assign w_auto_mask = w_auto_rise ? MASK_ALL : AUTO_SEQ[r_step_idx + 2'd1];

  // Hold counter and step index only advance while running; PEND/SETTLE freeze them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto_d   <= 1'b0;
      r_hold_cnt <= '0;
      r_step_idx <= '0;
    end else begin
      r_auto_d <= auto_en;
      if (w_auto_rise) begin
        r_hold_cnt <= '0;
        r_step_idx <= '0;
      end else if (w_auto_step) begin
        r_hold_cnt <= '0;
        r_step_idx <= r_step_idx + 2'd1;
      end else if (w_auto_adv) begin
        r_hold_cnt <= r_hold_cnt + HCNT_W'(1);
      end
    end
  end
`else
  localparam int p_unused_hold = HOLD_FRAMES;
  logic w_unused_auto;

  assign w_unused_auto = auto_en;
  assign w_ign_mask    = 1'b0;
  assign w_auto_load   = 1'b0;
  assign w_auto_mask   = MASK_ALL;
`endif

  assign w_mismatch = cfg_differs(w_req, r_act, w_ign_mask);

  // While auto-cycling, the mask belongs to the sequence, not to the request.
  always_comb begin
    w_commit = w_req;
    if (w_ign_mask) w_commit.mask = r_act.mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RUN;
      r_act        <= CFG_RESET;
      r_settle_cnt <= '0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_frame_tick) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      case (r_state)
        RUN: begin
          if (w_auto_load) r_act.mask <= w_auto_mask;
          if (w_mismatch) r_state <= PEND;
        end
        PEND: begin
          if (w_frame_tick) begin
            r_act <= w_commit;
            if (SETTLE_EN && (w_commit.pal != r_act.pal)) begin
              r_state      <= SETTLE;
              r_settle_cnt <= SETTLE_INIT;
            end else begin
              r_state <= RUN;
            end
          end else if (!w_mismatch) begin
            r_state <= RUN;
          end
        end
        SETTLE: begin
          if (w_frame_tick) begin
            if (r_settle_cnt == '0) r_state <= RUN;
            else                    r_settle_cnt <= r_settle_cnt - SCNT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign pal         = r_act.pal;
  assign range       = r_act.range;
  assign smpte       = r_act.smpte;
  assign chan_mask   = r_act.mask;
  assign force_blank = (r_state == SETTLE);
  assign busy        = (r_state != RUN);
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer (SETTLE_FRAMES=4, HOLD_FRAMES=2); observed bundle is
// {pal, range, smpte, chan_mask, force_blank, busy, frame_cnt}.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, ce_pix, vblank, req_pal, req_range, req_smpte, auto_en;
  logic [2:0]  req_mask;
  logic        pal, range, smpte, force_blank, busy;
  logic [2:0]  chan_mask;
  logic [15:0] frame_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  int          m_f = 0;
  int          c_busy = 0;
  int          c_fb = 0;
  int          c_mask = 0;
  logic [2:0]  m_mask;
  logic [23:0] sb_q[$];
  logic [23:0] w_obs;
  logic [23:0] exp_v;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .SETTLE_FRAMES (4),
    .HOLD_FRAMES   (2),
    .FCNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .vblank      (vblank),
    .req_pal     (req_pal),
    .req_range   (req_range),
    .req_smpte   (req_smpte),
    .req_mask    (req_mask),
    .auto_en     (auto_en),
    .pal         (pal),
    .range       (range),
    .smpte       (smpte),
    .chan_mask   (chan_mask),
    .force_blank (force_blank),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  assign w_obs = {pal, range, smpte, chan_mask, force_blank, busy, frame_cnt};

  always begin
    @(posedge clk);
    #2;
    if (busy === 1'b1) c_busy++;
    if (force_blank === 1'b1) c_fb++;
    if (chan_mask !== 3'b111) c_mask++;
  end

  function automatic logic [23:0] mk(logic [5:0] c, logic fb, logic bz, int f);
    return {c, fb, bz, 16'(f)};
  endfunction

  task automatic tick_cycle();
    vblank = 1'b1;
    @(negedge clk);
    m_f++;
  endtask

  task automatic frame_tail();
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_frame();
    tick_cycle();
    @(negedge clk);
    frame_tail();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce_pix = 1'b1; vblank = 1'b1; auto_en = 1'b0;
    req_pal = 1'b0; req_range = 1'b0; req_smpte = 1'b0; req_mask = 3'b111;
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, 0));
    repeat (3) @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL reset_values: got %h want %h", w_obs, exp_v); end
    reset_n = 1'b1;
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, 0));
    repeat (4) @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL release_vblank_high: got %h want %h", w_obs, exp_v); end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle_frames();
    int b0;
    b0 = c_busy;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, m_f + 1));
      do_frame();
      exp_v = sb_q.pop_front(); n_chk++;
      if (w_obs !== exp_v) begin n_fail++; $display("FAIL idle_frame%0d: got %h want %h", k, w_obs, exp_v); end
    end
    ce_pix = 1'b0; vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    ce_pix = 1'b1;
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, m_f));
    repeat (3) @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL ce_gate_no_tick: got %h want %h", w_obs, exp_v); end
    n_chk++;
    if (c_busy != b0) begin n_fail++; $display("FAIL idle_busy: got %0d busy cycles want 0", c_busy - b0); end
  endtask

  task automatic test_smpte_commit();
    int fb0;
    fb0 = c_fb;
    req_smpte = 1'b1;
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL smpte_busy_next: got %h want %h", w_obs, exp_v); end
    repeat (3) @(negedge clk);
    tick_cycle();
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b1, m_f - 1));
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL smpte_tick_cycle: got %h want %h", w_obs, exp_v); end
    sb_q.push_back(mk(6'b001111, 1'b0, 1'b0, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL smpte_commit: got %h want %h", w_obs, exp_v); end
    frame_tail();
    n_chk++;
    if (c_fb != fb0) begin n_fail++; $display("FAIL smpte_no_blank: got %0d blank cycles want 0", c_fb - fb0); end
  endtask

  task automatic test_pal_settle();
    req_pal = 1'b1;
    @(negedge clk);
    tick_cycle();
    sb_q.push_back(mk(6'b101111, 1'b1, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL pal_commit_blank: got %h want %h", w_obs, exp_v); end
    frame_tail();
    req_range = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sb_q.push_back(mk(6'b101111, 1'b1, 1'b1, m_f + 1));
      do_frame();
      exp_v = sb_q.pop_front(); n_chk++;
      if (w_obs !== exp_v) begin n_fail++; $display("FAIL settle_hold%0d: got %h want %h", k, w_obs, exp_v); end
    end
    tick_cycle();
    sb_q.push_back(mk(6'b101111, 1'b1, 1'b1, m_f - 1));
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL settle_last_tick: got %h want %h", w_obs, exp_v); end
    sb_q.push_back(mk(6'b101111, 1'b0, 1'b0, m_f));
    sb_q.push_back(mk(6'b101111, 1'b0, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL settle_exit: got %h want %h", w_obs, exp_v); end
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL settle_repend: got %h want %h", w_obs, exp_v); end
    frame_tail();
    sb_q.push_back(mk(6'b111111, 1'b0, 1'b0, m_f + 1));
    do_frame();
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL range_after_settle: got %h want %h", w_obs, exp_v); end
  endtask

  task automatic test_mask_cancel();
    int m0;
    m0 = c_mask;
    req_mask = 3'b011;
    sb_q.push_back(mk(6'b111111, 1'b0, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL mask_pend: got %h want %h", w_obs, exp_v); end
    req_mask = 3'b111;
    sb_q.push_back(mk(6'b111111, 1'b0, 1'b0, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL mask_cancel: got %h want %h", w_obs, exp_v); end
    sb_q.push_back(mk(6'b111111, 1'b0, 1'b0, m_f + 1));
    do_frame();
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL mask_no_commit: got %h want %h", w_obs, exp_v); end
    n_chk++;
    if (c_mask != m0) begin n_fail++; $display("FAIL mask_stays_all: got %0d changed cycles want 0", c_mask - m0); end
  endtask

  task automatic test_simultaneous();
    tick_cycle();
    req_smpte = 1'b0;
    sb_q.push_back(mk(6'b111111, 1'b0, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL tick_on_detect: got %h want %h", w_obs, exp_v); end
    frame_tail();
    sb_q.push_back(mk(6'b110111, 1'b0, 1'b0, m_f + 1));
    do_frame();
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL commit_next_frame: got %h want %h", w_obs, exp_v); end
    req_range = 1'b0;
    @(negedge clk);
    tick_cycle();
    req_range = 1'b1; req_mask = 3'b101;
    sb_q.push_back(mk(6'b110101, 1'b0, 1'b0, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL req_change_on_tick: got %h want %h", w_obs, exp_v); end
    frame_tail();
  endtask

  task automatic test_autocycle();
`ifdef PATSEQ_AUTOCYCLE_EN
    begin
      logic [2:0] seq [8];
      seq = '{3'b111, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b111};
      auto_en = 1'b1;
      sb_q.push_back(mk(6'b110111, 1'b0, 1'b0, m_f));
      @(negedge clk);
      exp_v = sb_q.pop_front(); n_chk++;
      if (w_obs !== exp_v) begin n_fail++; $display("FAIL auto_start: got %h want %h", w_obs, exp_v); end
      req_mask = 3'b011;
      for (int k = 0; k < 8; k++) sb_q.push_back(mk({3'b110, seq[k]}, 1'b0, 1'b0, m_f + k + 1));
      for (int k = 0; k < 8; k++) begin
        do_frame();
        exp_v = sb_q.pop_front(); n_chk++;
        if (w_obs !== exp_v) begin n_fail++; $display("FAIL auto_step%0d: got %h want %h", k, w_obs, exp_v); end
      end
      auto_en = 1'b0; req_mask = 3'b110;
      sb_q.push_back(mk(6'b110111, 1'b0, 1'b1, m_f));
      @(negedge clk);
      exp_v = sb_q.pop_front(); n_chk++;
      if (w_obs !== exp_v) begin n_fail++; $display("FAIL auto_off_pend: got %h want %h", w_obs, exp_v); end
      sb_q.push_back(mk(6'b110110, 1'b0, 1'b0, m_f + 1));
      do_frame();
      exp_v = sb_q.pop_front(); n_chk++;
      if (w_obs !== exp_v) begin n_fail++; $display("FAIL auto_off_commit: got %h want %h", w_obs, exp_v); end
      m_mask = 3'b110;
    end
`else
    auto_en = 1'b1; req_mask = 3'b011;
    sb_q.push_back(mk(6'b110101, 1'b0, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL auto_ignored_pend: got %h want %h", w_obs, exp_v); end
    sb_q.push_back(mk(6'b110011, 1'b0, 1'b0, m_f + 1));
    do_frame();
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL auto_ignored_commit: got %h want %h", w_obs, exp_v); end
    auto_en = 1'b0;
    m_mask = 3'b011;
`endif
  endtask

  task automatic test_reset_mid_settle();
    req_pal = 1'b0;
    @(negedge clk);
    sb_q.push_back(mk({3'b010, m_mask}, 1'b1, 1'b1, m_f + 1));
    do_frame();
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL pal_off_blank: got %h want %h", w_obs, exp_v); end
    repeat (4) do_frame();
    sb_q.push_back(mk({3'b010, m_mask}, 1'b0, 1'b0, m_f));
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL pal_off_settled: got %h want %h", w_obs, exp_v); end
    req_pal = 1'b1;
    @(negedge clk);
    tick_cycle();
    sb_q.push_back(mk({3'b110, m_mask}, 1'b1, 1'b1, m_f));
    @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL pal_on_blank: got %h want %h", w_obs, exp_v); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, 0));
    #1;
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL async_reset: got %h want %h", w_obs, exp_v); end
    req_pal = 1'b0; req_range = 1'b0; req_smpte = 1'b0; req_mask = 3'b111; auto_en = 1'b0;
    m_f = 0;
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, 0));
    repeat (4) @(negedge clk);
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL release_no_tick: got %h want %h", w_obs, exp_v); end
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, 1));
    do_frame();
    exp_v = sb_q.pop_front(); n_chk++;
    if (w_obs !== exp_v) begin n_fail++; $display("FAIL post_reset_frame: got %h want %h", w_obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_smpte_commit();
    test_pal_settle();
    test_mask_cancel();
    test_simultaneous();
    test_autocycle();
    test_reset_mid_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
